// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//   Shared definitions for the EX-stage branch resolution logic:
//   - funct3 encodings of the conditional branch comparisons
//   - the RUN/SQUASH state enum of the resolver
//   - small target-address helpers (all arithmetic wraps modulo 2^32)
// ---------------------------------------------------------------------------
package branch_pkg;

   // Conditional branch condition codes (funct3 field).
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Size of one instruction; the fall-through address is pc + INSTR_BYTES.
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // RUN: EX holds a right-path instruction.
   // SQUASH: the cycle after a redirect; EX holds a wrong-path instruction.
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } state_e;

   // PC-relative target (JAL, taken conditional branch).
   function automatic logic [31:0] pc_rel_target(input logic [31:0] pc,
                                                 input logic [31:0] imm);
      return pc + imm;
   endfunction

   // Register-indirect target (JALR): bit 0 of the sum is forced to zero.
   function automatic logic [31:0] jalr_target(input logic [31:0] rs1,
                                               input logic [31:0] imm);
      logic [31:0] sum;
      sum = rs1 + imm;
      return {sum[31:1], 1'b0};
   endfunction

endpackage

// File: rtl/branch_comparator.sv
// ---------------------------------------------------------------------------
// branch_comparator
//   Purely combinational evaluation of a conditional branch condition.
//   Ports:
//     funct3_i  [2:0]  branch condition code
//     rs1_i     [31:0] first operand (forwarded)
//     rs2_i     [31:0] second operand (forwarded)
//     taken_o          1 when the condition holds; reserved codes 010/011
//                      always evaluate to not-taken
// ---------------------------------------------------------------------------
module branch_comparator
   import branch_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   output logic        taken_o
);

   logic eq;
   logic lt_signed;
   logic lt_unsigned;

   assign eq          = (rs1_i == rs2_i);
   assign lt_signed   = ($signed(rs1_i) < $signed(rs2_i));
   assign lt_unsigned = (rs1_i < rs2_i);

   // NOTE: a default before the case keeps every path assigned, so no latch
   // is inferred for the unlisted (reserved) funct3 codes.
   always_comb begin
      taken_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  taken_o = eq;
         F3_BNE:  taken_o = ~eq;
         F3_BLT:  taken_o = lt_signed;
         F3_BGE:  taken_o = ~lt_signed;
         F3_BLTU: taken_o = lt_unsigned;
         F3_BGEU: taken_o = ~lt_unsigned;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//   EX-stage branch/jump resolution. Evaluates conditional branches, detects
//   mispredictions, computes redirect targets for branches and JAL/JALR, and
//   produces registered redirect/flush pulses, predictor updates and
//   performance counters.
//   Ports:
//     i_clk, i_reset_n        clock, synchronous active-low reset
//     i_valid, i_stall        EX holds a valid instruction / EX is held
//     i_is_branch/jal/jalr    decoded instruction class
//     i_funct3                branch condition
//     i_rs1_data, i_rs2_data  forwarded operands
//     i_pc, i_imm             EX PC and sign-extended immediate
//     i_pred_taken            prediction carried from ID
//     o_redirect, o_flush     one-cycle redirect pulse and pipeline kill
//     o_redirect_pc           redirect target (held between pulses)
//     o_bp_wen, o_bp_pc,
//     o_bp_actual_taken       predictor update (pc/outcome held between pulses)
//     o_br_count              resolved conditional branches
//     o_mispred_count         mispredicted conditional branches
// ---------------------------------------------------------------------------
module branch_resolver
   import branch_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_valid,
   input  logic        i_stall,
   input  logic        i_is_branch,
   input  logic        i_is_jal,
   input  logic        i_is_jalr,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_imm,
   input  logic        i_pred_taken,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc,
   output logic        o_flush,
   output logic        o_bp_wen,
   output logic [31:0] o_bp_pc,
   output logic        o_bp_actual_taken,
   output logic [31:0] o_br_count,
   output logic [31:0] o_mispred_count
);

   state_e      state_q, state_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        bp_wen_q, bp_wen_d;
   logic [31:0] bp_pc_q, bp_pc_d;
   logic        bp_actual_q, bp_actual_d;
   logic [31:0] br_count_q, br_count_d;
   logic [31:0] mispred_count_q, mispred_count_d;

   logic        resolve;
   logic        br_resolve;
   logic        cond_taken;
   logic        mispred;

   branch_comparator u_cmp (
      .funct3_i (i_funct3),
      .rs1_i    (i_rs1_data),
      .rs2_i    (i_rs2_data),
      .taken_o  (cond_taken)
   );

   // An instruction resolves only once: when it is valid, no longer held,
   // and not on the wrong path behind a redirect.
   assign resolve    = i_valid & ~i_stall & (state_q == ST_RUN);
   // Jumps take precedence should a decoder ever flag more than one class.
   assign br_resolve = resolve & i_is_branch & ~i_is_jal & ~i_is_jalr;
   assign mispred    = br_resolve & (cond_taken != i_pred_taken);

   always_comb begin
      state_d         = state_q;
      redirect_d      = 1'b0;
      redirect_pc_d   = redirect_pc_q;
      bp_wen_d        = 1'b0;
      bp_pc_d         = bp_pc_q;
      bp_actual_d     = bp_actual_q;
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;

      if (resolve) begin
         if (i_is_jal) begin
            redirect_d    = 1'b1;
            redirect_pc_d = pc_rel_target(i_pc, i_imm);
         end else if (i_is_jalr) begin
            redirect_d    = 1'b1;
            redirect_pc_d = jalr_target(i_rs1_data, i_imm);
         end else if (i_is_branch) begin
            bp_wen_d    = 1'b1;
            bp_pc_d     = i_pc;
            bp_actual_d = cond_taken;
            br_count_d  = br_count_q + 32'd1;
            if (mispred) begin
               redirect_d      = 1'b1;
               mispred_count_d = mispred_count_q + 32'd1;
               redirect_pc_d   = cond_taken ? pc_rel_target(i_pc, i_imm)
                                            : (i_pc + INSTR_BYTES);
            end
         end
      end

      // The squash lasts exactly the one cycle in which the redirect pulse
      // is visible; the instruction in EX during it is wrong-path.
      case (state_q)
         ST_RUN:    state_d = redirect_d ? ST_SQUASH : ST_RUN;
         ST_SQUASH: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase
   end

   // NOTE: non-blocking assignments for all state so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q         <= ST_RUN;
         redirect_q      <= 1'b0;
         redirect_pc_q   <= 32'h0;
         bp_wen_q        <= 1'b0;
         bp_pc_q         <= 32'h0;
         bp_actual_q     <= 1'b0;
         br_count_q      <= 32'h0;
         mispred_count_q <= 32'h0;
      end else begin
         state_q         <= state_d;
         redirect_q      <= redirect_d;
         redirect_pc_q   <= redirect_pc_d;
         bp_wen_q        <= bp_wen_d;
         bp_pc_q         <= bp_pc_d;
         bp_actual_q     <= bp_actual_d;
         br_count_q      <= br_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   assign o_redirect        = redirect_q;
   assign o_flush           = redirect_q;
   assign o_redirect_pc     = redirect_pc_q;
   assign o_bp_wen          = bp_wen_q;
   assign o_bp_pc           = bp_pc_q;
   assign o_bp_actual_taken = bp_actual_q;
   assign o_br_count        = br_count_q;
   assign o_mispred_count   = mispred_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
//   Self-checking bench for branch_resolver: directed scenarios followed by
//   randomized traffic, all compared against a cycle-level behavioural model.
// ---------------------------------------------------------------------------
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, stall, is_branch, is_jal, is_jalr, pred;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2, pc, imm;
   logic        redirect, flush, bp_wen, bp_act;
   logic [31:0] redirect_pc, bp_pc, br_count, mis_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Model of the architecturally visible outputs.
   bit          m_wrong_path;
   bit          m_redirect;
   logic [31:0] m_redirect_pc;
   bit          m_bp_wen;
   logic [31:0] m_bp_pc;
   bit          m_bp_act;
   logic [31:0] m_br_cnt;
   logic [31:0] m_mis_cnt;

   always #5 clk = ~clk;

   branch_resolver dut (
      .i_clk             (clk),
      .i_reset_n         (rst_n),
      .i_valid           (valid),
      .i_stall           (stall),
      .i_is_branch       (is_branch),
      .i_is_jal          (is_jal),
      .i_is_jalr         (is_jalr),
      .i_funct3          (funct3),
      .i_rs1_data        (rs1),
      .i_rs2_data        (rs2),
      .i_pc              (pc),
      .i_imm             (imm),
      .i_pred_taken      (pred),
      .o_redirect        (redirect),
      .o_redirect_pc     (redirect_pc),
      .o_flush           (flush),
      .o_bp_wen          (bp_wen),
      .o_bp_pc           (bp_pc),
      .o_bp_actual_taken (bp_act),
      .o_br_count        (br_count),
      .o_mispred_count   (mis_count)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Signed order obtained by biasing both operands into unsigned range.
   function automatic bit ref_taken(input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ab, bb;
      ab = a ^ 32'h8000_0000;
      bb = b ^ 32'h8000_0000;
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return ab < bb;
         3'd5:    return ab >= bb;
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Advance the model by one clock using the currently driven inputs, clock
   // the DUT, then compare every output 1 time unit after the edge.
   task automatic step();
      bit          take;
      bit          redir;
      bit          upd;
      logic [31:0] tgt;
      redir = 1'b0;
      upd   = 1'b0;
      tgt   = 32'h0;
      if (!rst_n) begin
         m_wrong_path  = 1'b0;
         m_redirect    = 1'b0;
         m_redirect_pc = 32'h0;
         m_bp_wen      = 1'b0;
         m_bp_pc       = 32'h0;
         m_bp_act      = 1'b0;
         m_br_cnt      = 32'h0;
         m_mis_cnt     = 32'h0;
      end else begin
         if (valid && !stall && !m_wrong_path) begin
            if (is_jal) begin
               redir = 1'b1;
               tgt   = pc + imm;
            end else if (is_jalr) begin
               redir = 1'b1;
               tgt   = (rs1 + imm) & 32'hFFFF_FFFE;
            end else if (is_branch) begin
               take      = ref_taken(funct3, rs1, rs2);
               upd       = 1'b1;
               m_bp_pc   = pc;
               m_bp_act  = take;
               m_br_cnt  = m_br_cnt + 1;
               if (take != pred) begin
                  redir     = 1'b1;
                  m_mis_cnt = m_mis_cnt + 1;
                  tgt       = take ? pc + imm : pc + 4;
               end
            end
         end
         m_redirect   = redir;
         m_bp_wen     = upd;
         m_wrong_path = redir;
         if (redir) m_redirect_pc = tgt;
      end
      @(posedge clk);
      #1;
      check("redirect",    {31'b0, redirect}, {31'b0, m_redirect});
      check("flush",       {31'b0, flush},    {31'b0, m_redirect});
      check("redirect_pc", redirect_pc,       m_redirect_pc);
      check("bp_wen",      {31'b0, bp_wen},   {31'b0, m_bp_wen});
      check("bp_pc",       bp_pc,             m_bp_pc);
      check("bp_actual",   {31'b0, bp_act},   {31'b0, m_bp_act});
      check("br_count",    br_count,          m_br_cnt);
      check("mis_count",   mis_count,         m_mis_cnt);
   endtask

   task automatic idle();
      valid = 1'b0; stall = 1'b0;
      is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
      pred = 1'b0; funct3 = 3'd0;
      rs1 = 32'h0; rs2 = 32'h0; pc = 32'h0; imm = 32'h0;
   endtask

   task automatic set_br(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p,
                         input logic [31:0] i, input logic pr);
      idle();
      valid = 1'b1; is_branch = 1'b1;
      funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; pred = pr;
   endtask

   task automatic set_jump(input bit jalr, input logic [31:0] a,
                           input logic [31:0] p, input logic [31:0] i);
      idle();
      valid = 1'b1; is_jal = ~jalr; is_jalr = jalr;
      rs1 = a; pc = p; imm = i;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] br_before, mis_before;
      int          wen_seen;

      idle();
      rst_n = 1'b0;
      step();
      step();
      check("reset_redirect", {31'b0, redirect}, 32'd0);
      check("reset_br_count", br_count, 32'd0);

      // First cycle after release with nothing in EX: no pulse.
      rst_n = 1'b1;
      step();

      // Correctly predicted taken BEQ.
      set_br(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
      step();
      check("p1_redirect", {31'b0, redirect}, 32'd0);
      check("p1_bp_wen",   {31'b0, bp_wen},   32'd1);
      check("p1_bp_pc",    bp_pc,             32'h100);
      check("p1_actual",   {31'b0, bp_act},   32'd1);
      check("p1_br",       br_count,          32'd1);
      check("p1_mis",      mis_count,         32'd0);

      // BLT -1 < 0 predicted not-taken; the next BNE is wrong-path.
      set_br(3'b100, 32'hFFFF_FFFF, 32'h0, 32'h200, 32'h40, 1'b0);
      step();
      check("p2_redirect", {31'b0, redirect}, 32'd1);
      check("p2_flush",    {31'b0, flush},    32'd1);
      check("p2_pc",       redirect_pc,       32'h240);
      check("p2_actual",   {31'b0, bp_act},   32'd1);
      check("p2_mis",      mis_count,         32'd1);
      set_br(3'b001, 32'd1, 32'd2, 32'h204, 32'h80, 1'b0);
      step();
      check("p2_squash_redirect", {31'b0, redirect}, 32'd0);
      check("p2_squash_wen",      {31'b0, bp_wen},   32'd0);
      check("p2_squash_br",       br_count,          32'd2);

      // BLTU 0xFFFFFFFF < 1 is false, predicted taken.
      set_br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h80, 1'b1);
      step();
      check("p3_redirect", {31'b0, redirect}, 32'd1);
      check("p3_pc",       redirect_pc,       32'h304);
      check("p3_actual",   {31'b0, bp_act},   32'd0);
      idle();
      step();

      // JALR clears bit 0 and leaves predictor and counters alone.
      br_before  = br_count;
      mis_before = mis_count;
      set_jump(1'b1, 32'h1001, 32'h400, 32'h10);
      step();
      check("p4_redirect", {31'b0, redirect}, 32'd1);
      check("p4_pc",       redirect_pc,       32'h1010);
      check("p4_bp_wen",   {31'b0, bp_wen},   32'd0);
      check("p4_br",       br_count,          br_before);
      check("p4_mis",      mis_count,         mis_before);
      idle();
      step();

      // JAL target wraps around 2^32.
      set_jump(1'b0, 32'h0, 32'hFFFF_FFF0, 32'h20);
      step();
      check("wrap_pc", redirect_pc, 32'h10);
      idle();
      step();
      check("hold_pc", redirect_pc, 32'h10);

      // BNE held three cycles, then released: exactly one update.
      br_before = br_count;
      wen_seen  = 0;
      set_br(3'b001, 32'd3, 32'd4, 32'h600, 32'h8, 1'b1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         wen_seen += int'(bp_wen);
      end
      stall = 1'b0;
      step();
      wen_seen += int'(bp_wen);
      idle();
      step();
      wen_seen += int'(bp_wen);
      check("stall_wen_count", wen_seen, 32'd1);
      check("stall_br",        br_count, br_before + 32'd1);

      // Reset asserted while the redirect pulse is visible.
      set_br(3'b000, 32'd1, 32'd2, 32'h700, 32'h10, 1'b1);
      step();
      check("p6_pulse", {31'b0, redirect}, 32'd1);
      idle();
      rst_n = 1'b0;
      step();
      check("p6_redirect", {31'b0, redirect}, 32'd0);
      check("p6_pc",       redirect_pc,       32'd0);
      check("p6_br",       br_count,          32'd0);
      check("p6_mis",      mis_count,         32'd0);
      // Back in RUN: a branch right after release resolves.
      rst_n = 1'b1;
      set_br(3'b000, 32'd1, 32'd1, 32'h500, 32'h8, 1'b0);
      step();
      check("p6_run_redirect", {31'b0, redirect}, 32'd1);
      check("p6_run_pc",       redirect_pc,       32'h508);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         int cls;
         idle();
         rst_n  = ($urandom_range(0, 99) != 0);
         valid  = ($urandom_range(0, 9) < 7);
         stall  = ($urandom_range(0, 3) == 0);
         cls    = $urandom_range(0, 3);
         is_branch = (cls == 1);
         is_jal    = (cls == 2);
         is_jalr   = (cls == 3);
         funct3 = 3'($urandom_range(0, 7));
         rs1    = pick_operand();
         rs2    = ($urandom_range(0, 3) == 0) ? rs1 : pick_operand();
         pc     = $urandom;
         imm    = pick_operand();
         pred   = 1'($urandom_range(0, 1));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have port i_clk, input, 1, rising-edge clock.
REQ-002 SHALL have port i_reset_n, input, 1: reset, synchronous, active-low; clock i_clk.
REQ-003 SHALL have port i_valid, input, 1: EX stage holds a valid instruction.
REQ-004 SHALL have port i_stall, input, 1: EX stage held this cycle.
REQ-005 SHALL have ports i_is_branch, i_is_jal, i_is_jalr, input, 1 each: decoded instruction class.
REQ-006 SHALL have port i_funct3, input, 3: branch condition.
REQ-007 SHALL have ports i_rs1_data, i_rs2_data, i_pc, i_imm, input, 32 each: forwarded operands, EX PC, and sign-extended immediate.
REQ-008 SHALL have port i_pred_taken, input, 1: prediction carried from ID.
REQ-009 SHALL have ports o_redirect (1) and o_redirect_pc (32), output: fetch redirect pulse and its target.
REQ-010 SHALL have port o_flush, output, 1: kill IF/ID and ID/EX.
REQ-011 SHALL have ports o_bp_wen (1), o_bp_pc (32) and o_bp_actual_taken (1), output: predictor update port.
REQ-012 SHALL have ports o_br_count and o_mispred_count, output, 32 each: performance counters.

Function
REQ-013 SHALL resolve an instruction in a cycle when i_valid=1, i_stall=0 and state=RUN.
  - i_stall=1: no resolution; the held instruction resolves once, in the cycle stall drops.
REQ-014 SHALL evaluate conditions combinationally: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010 and 011: not taken.
REQ-015 SHALL treat a conditional branch as mispredicted iff actual_taken != i_pred_taken.
  - Taken correction target: i_pc+i_imm.
  - Not-taken correction target: i_pc+4.
REQ-016 SHALL always redirect resolved JAL and JALR.
  - JAL target: i_pc+i_imm.
  - JALR target: (i_rs1_data+i_imm) with bit0 cleared.
  - JAL/JALR SHALL NOT update the predictor or the counters.
REQ-017 SHALL perform all address arithmetic modulo 2^32 (wrap), without alignment checks.
REQ-018 SHALL register redirect outputs.
  - A redirect resolved in cycle N gives o_redirect=1, o_flush=1 and o_redirect_pc valid in cycle N+1 only (one-cycle pulse).
  - The pulse is independent of i_stall.
REQ-019 SHALL use FSM states RUN and SQUASH.
  - RUN->SQUASH on any redirect-causing resolution.
  - SQUASH->RUN unconditionally after one cycle.
  - In SQUASH the EX instruction is wrong-path: no resolution, no redirect, no update, no count.
REQ-020 SHALL register the predictor update for every resolved conditional branch.
  - o_bp_wen=1 in cycle N+1 for exactly one cycle.
  - o_bp_pc = i_pc of the branch; o_bp_actual_taken = outcome.
REQ-021 SHALL increment o_br_count on each resolved conditional branch and o_mispred_count on each conditional misprediction, both wrapping at 2^32.
REQ-022 SHALL hold o_redirect_pc, o_bp_pc and o_bp_actual_taken at their last values when the associated strobe is 0.
REQ-023 SHALL give reset priority over everything if i_reset_n=0 while state=SQUASH or a pulse is pending: the pending pulse is dropped.

Reset
REQ-024 SHALL, on i_reset_n=0 at a rising edge:
  - state = RUN.
  - o_redirect, o_flush, o_bp_wen, o_bp_actual_taken = 0.
  - o_redirect_pc, o_bp_pc = 32'h0.
  - Both counters = 0.
REQ-025 SHALL produce no redirect or update in the first cycle after reset release, unless an instruction resolves in that cycle.

Structure
REQ-026 SHALL place funct3 condition constants and the RUN/SQUASH state enum in shared package branch_pkg.
REQ-027 SHALL implement the condition evaluation as the combinational sub-module branch_comparator (funct3, rs1, rs2 -> taken).

Verification
REQ-028 Verification SHALL cover a correct prediction:
  - Stimulus: BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=1.
  - Response: no redirect; next cycle bp_wen=1, bp_pc=0x100, actual=1; br_count=1, mispred_count=0.
REQ-029 Verification SHALL cover a mispredicted not-taken branch:
  - Stimulus: BLT, rs1=-1, rs2=0, pc=0x200, imm=0x40, pred=0.
  - Response: next cycle redirect=1, flush=1, pc=0x240, bp_actual=1, mispred_count=1.
  - Following cycle: a valid BNE in EX is ignored.
REQ-030 Verification SHALL cover a mispredicted taken branch:
  - Stimulus: BLTU, rs1=0xFFFFFFFF, rs2=1, pc=0x300, pred=1.
  - Response: redirect to 0x304, actual=0.
REQ-031 Verification SHALL cover JALR:
  - Stimulus: rs1=0x1001, imm=0x10.
  - Response: redirect to 0x1010, no bp_wen, counters unchanged.
REQ-032 Verification SHALL cover a stalled branch:
  - Stimulus: BNE held with i_stall=1 for 3 cycles, then released.
  - Response: exactly one bp_wen and br_count+1, following the release cycle.
REQ-033 Verification SHALL cover reset during a pulse:
  - Stimulus: reset asserted in the redirect cycle.
  - Response: all outputs 0, state RUN next cycle, counters 0.
